// File: rtl/fp_norm_round.sv
// fp_norm_round -- normalise, RNE-round and pack an FP adder sum into an IEEE-754 single.
// Rev 1.0: two-stage valid/ready pipeline, flush-to-zero, no subnormal results.
`default_nettype none

module fp_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_sign,
  input  logic [EXP_W-1:0]          in_exp,
  input  logic [FRAC_W+3:0]         in_mant,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [EXP_W+FRAC_W:0]     out_result,
  output logic [2:0]                out_flags
);

  localparam int c_MW  = FRAC_W + 4;   // {carry, int, frac, guard, sticky}
  localparam int c_NB  = FRAC_W + 3;   // {int, frac, guard, sticky}
  localparam int c_LZW = $clog2(c_NB);
  localparam int c_EW2 = EXP_W + 2;
  localparam logic signed [c_EW2-1:0] c_EXP_MAX  = c_EW2'((1 << EXP_W) - 1);
  localparam logic signed [c_EW2-1:0] c_EXP_ZERO = '0;

  logic                      r_s1_valid;
  logic                      r_s1_sign;
  logic signed [c_EW2-1:0]   r_s1_exp;
  logic [FRAC_W-1:0]         r_s1_frac;
  logic                      r_s1_guard;
  logic                      r_s1_sticky;
  logic                      r_s1_zero;

  logic                      r_s2_valid;
  logic [EXP_W+FRAC_W:0]     r_res;
  logic [2:0]                r_flags;

  logic                      w_s2_load;
  logic                      w_s1_load;
  logic [c_LZW-1:0]          w_lzc;
  logic [c_NB-1:0]           w_norm;
  logic signed [c_EW2-1:0]   w_exp_in;
  logic signed [c_EW2-1:0]   w_exp_n;
  logic [FRAC_W-1:0]         w_frac_n;
  logic                      w_guard_n;
  logic                      w_sticky_n;
  logic                      w_zero_n;

  logic                      w_rnd_up;
  logic                      w_inexact;
  logic [FRAC_W:0]           w_frac_sum;
  logic signed [c_EW2-1:0]   w_exp_r;
  logic [EXP_W+FRAC_W:0]     w_res;
  logic [2:0]                w_flags;

  assign w_s2_load  = !r_s2_valid || out_ready;
  assign w_s1_load  = !r_s1_valid || w_s2_load;
  assign in_ready   = w_s1_load;
  assign out_valid  = r_s2_valid;
  assign out_result = r_res;
  assign out_flags  = r_flags;

  // Stage 1: normalise so the leading one sits at the integer position.
  always_comb begin
    w_lzc = '0;
    for (int i = 0; i < c_NB; i++) begin
      if (in_mant[i]) w_lzc = c_LZW'(c_NB - 1 - i);
    end
    w_norm     = in_mant[c_NB-1:0] << w_lzc;
    w_exp_in   = c_EW2'(in_exp);
    w_frac_n   = w_norm[c_NB-2:2];
    w_guard_n  = w_norm[1];
    w_sticky_n = w_norm[0];
    w_exp_n    = w_exp_in - c_EW2'(w_lzc);
    // A shift leaving the integer bit clear means nothing was set at all.
    w_zero_n   = !w_norm[c_NB-1];
    if (in_mant[c_MW-1]) begin
      w_frac_n   = in_mant[c_MW-2:3];
      w_guard_n  = in_mant[2];
      w_sticky_n = |in_mant[1:0];
      w_exp_n    = w_exp_in + c_EW2'(1);
      w_zero_n   = 1'b0;
    end
  end

  // Stage 2: round to nearest even, then saturate or flush the exponent.
  always_comb begin
    w_rnd_up   = r_s1_guard && (r_s1_sticky || r_s1_frac[0]);
    w_inexact  = r_s1_guard || r_s1_sticky;
    w_frac_sum = {1'b0, r_s1_frac} + {{FRAC_W{1'b0}}, w_rnd_up};
    w_exp_r    = r_s1_exp + {{(c_EW2-1){1'b0}}, w_frac_sum[FRAC_W]};
    w_res      = '0;
    w_flags    = '0;
    if (r_s1_zero) begin
      w_res   = '0;
      w_flags = '0;
    end else if (w_exp_r >= c_EXP_MAX) begin
      w_res   = {r_s1_sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      w_flags = 3'b101;
    end else if (w_exp_r <= c_EXP_ZERO) begin
      w_res   = {r_s1_sign, {(EXP_W+FRAC_W){1'b0}}};
      w_flags = 3'b011;
    end else begin
      w_res   = {r_s1_sign, w_exp_r[EXP_W-1:0], w_frac_sum[FRAC_W-1:0]};
      w_flags = {2'b00, w_inexact};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_exp    <= '0;
      r_s1_frac   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_zero   <= 1'b0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign   <= in_sign;
        r_s1_exp    <= w_exp_n;
        r_s1_frac   <= w_frac_n;
        r_s1_guard  <= w_guard_n;
        r_s1_sticky <= w_sticky_n;
        r_s1_zero   <= w_zero_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fp_norm_round.sv
// tb_fp_norm_round -- directed vector table, stall/reset sequences and randomized
// operands against a significand-arithmetic reference model.
`default_nettype none

module tb_fp_norm_round;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [2:0]  out_flags;

  int n_vec = 0;
  int n_err = 0;
  int out_idx = 0;
  bit done = 0;
  logic [34:0] exp_q[$];

  typedef struct {
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic [31:0] r;
    logic [2:0]  f;
  } vec_t;

  vec_t tbl[16];

  fp_norm_round #(.EXP_W(8), .FRAC_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [34:0] act, input logic [34:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, expv);
    end
  endtask

  // Reference: locate the leading one, keep 24 significant bits, round the rest RNE.
  function automatic logic [34:0] model(input logic s, input logic [7:0] e, input logic [26:0] m);
    longint unsigned m64, kept, rem, half, one;
    int p, ex;
    bit g, st, inx;
    logic [31:0] res;
    logic [2:0] fl;
    if (m == 27'd0) return 35'd0;
    one = 1;
    m64 = longint'(m);
    p = 26;
    while (!m[p]) p--;
    ex = int'(e) + p - 25;
    if (p > 23) begin
      kept = m64 >> (p - 23);
      rem  = m64 & ((one << (p - 23)) - 1);
      half = one << (p - 24);
      g    = (rem >= half);
      st   = ((rem & (half - 1)) != 0);
      inx  = (rem != 0);
    end else begin
      kept = m64 << (23 - p);
      g = 0; st = 0; inx = 0;
    end
    if (g && (st || ((kept & 1) != 0))) kept++;
    if (kept == (one << 24)) begin
      kept = kept >> 1;
      ex++;
    end
    if (ex >= 255) begin
      res = {s, 8'hFF, 23'h0};
      fl  = 3'b101;
    end else if (ex <= 0) begin
      res = {s, 31'h0};
      fl  = 3'b011;
    end else begin
      res = {s, 8'(ex), 23'(kept)};
      fl  = {2'b00, inx};
    end
    return {res, fl};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %h, want none", {out_result, out_flags});
      end else begin
        check($sformatf("stream[%0d]", out_idx), {out_result, out_flags}, exp_q.pop_front());
      end
      out_idx++;
    end
  end

  task automatic push(input logic s, input logic [7:0] e, input logic [26:0] m,
                      input logic [34:0] expv);
    int n = 0;
    bit acc = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (in_ready) acc = 1;
      else n++;
    end
    if (!acc) begin
      n_vec++;
      n_err++;
      $display("FAIL push_timeout: in_ready stayed 0, want 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back(expv);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic latency(input string tag, input logic [34:0] expv);
    @(negedge clk);
    check({tag, "_pre"}, 35'(out_valid), 35'(0));
    @(negedge clk);
    check({tag, "_valid"}, 35'(out_valid), 35'(1));
    check({tag, "_data"}, {out_result, out_flags}, expv);
  endtask

  initial begin
    time t0;
    logic        rs;
    logic [7:0]  re;
    logic [26:0] rm;

    tbl[0]  = '{1'b0, 8'h7F, 27'h6000000, 32'h40400000, 3'b000};
    tbl[1]  = '{1'b0, 8'h7F, 27'h0000004, 32'h34000000, 3'b000};
    tbl[2]  = '{1'b0, 8'h7F, 27'h2000006, 32'h3F800002, 3'b001};
    tbl[3]  = '{1'b0, 8'h7F, 27'h2000002, 32'h3F800000, 3'b001};
    tbl[4]  = '{1'b0, 8'hFE, 27'h6000000, 32'h7F800000, 3'b101};
    tbl[5]  = '{1'b0, 8'h01, 27'h1000000, 32'h00000000, 3'b011};
    tbl[6]  = '{1'b1, 8'h7F, 27'h2000000, 32'hBF800000, 3'b000};
    tbl[7]  = '{1'b1, 8'h50, 27'h0000000, 32'h00000000, 3'b000};
    tbl[8]  = '{1'b0, 8'h7F, 27'h3FFFFFE, 32'h40000000, 3'b001};
    tbl[9]  = '{1'b0, 8'hFF, 27'h2000000, 32'h7F800000, 3'b101};
    tbl[10] = '{1'b1, 8'h7F, 27'h0000001, 32'hB3000000, 3'b000};
    tbl[11] = '{1'b0, 8'h7F, 27'h2000003, 32'h3F800001, 3'b001};
    tbl[12] = '{1'b0, 8'h7F, 27'h2000001, 32'h3F800000, 3'b001};
    tbl[13] = '{1'b0, 8'h19, 27'h0000001, 32'h00000000, 3'b011};
    tbl[14] = '{1'b0, 8'h1A, 27'h0000001, 32'h00800000, 3'b000};
    tbl[15] = '{1'b1, 8'hFE, 27'h4000001, 32'hFF800000, 3'b101};

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_exp    = '0;
    in_mant   = '0;
    out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 35'(out_valid), 35'(0));
    check("rst_out_result", 35'(out_result), 35'(0));
    check("rst_out_flags", 35'(out_flags), 35'(0));
    check("rst_in_ready", 35'(in_ready), 35'(1));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single operand: result appears on the second edge after acceptance.
    push(tbl[0].s, tbl[0].e, tbl[0].m, {tbl[0].r, tbl[0].f});
    in_valid = 1'b0;
    latency("lat", {tbl[0].r, tbl[0].f});
    @(posedge clk);
    #1;

    // Whole table back to back; one acceptance per cycle.
    t0 = $time;
    for (int i = 0; i < 16; i++) push(tbl[i].s, tbl[i].e, tbl[i].m, {tbl[i].r, tbl[i].f});
    in_valid = 1'b0;
    check("throughput", 35'($time - t0), 35'(16 * 10));
    drain();

    // Stall: two operands fill the pipe, the third waits until the sink resumes.
    out_ready = 1'b0;
    push(tbl[0].s, tbl[0].e, tbl[0].m, {tbl[0].r, tbl[0].f});
    push(tbl[1].s, tbl[1].e, tbl[1].m, {tbl[1].r, tbl[1].f});
    fork
      push(tbl[6].s, tbl[6].e, tbl[6].m, {tbl[6].r, tbl[6].f});
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", 35'(in_ready), 35'(0));
          check("stall_hold", 35'({out_valid, out_result, out_flags}), {1'b1, tbl[0].r, tbl[0].f});
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    in_valid = 1'b0;
    drain();

    // Asynchronous reset with both stages occupied.
    out_ready = 1'b0;
    push(tbl[3].s, tbl[3].e, tbl[3].m, {tbl[3].r, tbl[3].f});
    push(tbl[4].s, tbl[4].e, tbl[4].m, {tbl[4].r, tbl[4].f});
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 35'(out_valid), 35'(0));
    check("arst_out_result", 35'(out_result), 35'(0));
    check("arst_in_ready", 35'(in_ready), 35'(1));
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    push(tbl[2].s, tbl[2].e, tbl[2].m, {tbl[2].r, tbl[2].f});
    in_valid = 1'b0;
    latency("arst_lat", {tbl[2].r, tbl[2].f});
    @(posedge clk);
    #1;

    // Randomized operands with random sink backpressure and source gaps.
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          rs = 1'($urandom_range(0, 1));
          re = 8'($urandom_range(0, 255));
          rm = 27'($urandom);
          rm = rm >> $urandom_range(0, 27);
          if ($urandom_range(0, 19) == 0) rm = '0;
          push(rs, re, rm, model(rs, re, rm));
          if ($urandom_range(0, 7) == 0) begin
            in_valid = 1'b0;
            @(posedge clk);
            #1;
          end
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
